div128_64_seq: RTL
==================

Name: div128_64_seq

Overview:
- Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, giving a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Inverse companion of the 64x64->128 combinational multiplier. Takes a full product back to its factors for self-checking datapaths.
- Computes one quotient bit per clock. Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 64, divisor/remainder width; dividend and quotient are 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  2*WIDTH  numerator, captured when start accepted
- divisor  input  WIDTH  denominator, captured when start accepted
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- quotient  output  2*WIDTH  unsigned quotient, held until next accepted start
- remainder  output  WIDTH  unsigned remainder, held likewise
- div_by_zero  output  1  divisor was zero (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0.
  - Reset mid-operation aborts the operation immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge N:
  - Capture the operands.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
  - Go to RUN; busy=1 from edge N.
- DONE lasts exactly one cycle. With start=0 it returns to IDLE; with start=1 it accepts a new operation (back-to-back).
- RUN, each edge:
  - pr = {pr[WIDTH-1:0], next dividend MSB}.
  - If pr >= divisor: pr -= divisor and shift quotient bit 1 in; else shift 0 in.
  - Exactly 2*WIDTH iterations.
  - The last iteration is at edge N+2*WIDTH. That edge sets state=DONE, busy=0, done=1, and loads the quotient/remainder outputs.
  - Latency start->done = 2*WIDTH cycles (128 at default).
- start while busy=1 is ignored. Operand inputs are don't-care while busy.
- Outputs quotient/remainder change only on the done edge; stable otherwise.
- All arithmetic is unsigned. The subtract compare uses WIDTH+1 bits so no overflow is lost.
- Divisor > dividend: quotient=0, remainder=dividend[WIDTH-1:0]. Normal latency.
- Divisor=0 (algorithm result): quotient all ones, remainder=dividend[WIDTH-1:0].

Optional Feature:
- Macro DIV_ZERO_CHECK_EN.
- Defined:
  - Divisor=0 is detected at start acceptance; go directly to DONE on the next edge (latency 1).
  - Outputs: quotient all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1 with done.
  - div_by_zero is cleared at the next accepted start.
- Undefined:
  - No special path; the full 2*WIDTH-cycle iteration runs and yields the same quotient/remainder values.
  - div_by_zero is tied 0.

Test Plan:
- dividend = 0xAAAA_AAAA_AAAA_AAAA * 0x5555_5555_5555_5555 (128-bit product), divisor=0x5555_5555_5555_5555 -> after 128 cycles done=1, quotient=0x0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA, remainder=0.
- dividend=100, divisor=7 -> quotient=14, remainder=2, done exactly 128 cycles after start; busy high for those 128 cycles. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=all ones (2^128-1), divisor=1 -> quotient=all ones, remainder=0.
- Start pulsed again at cycle 40 of a running op with other operands -> ignored; first result delivered unchanged. Start held high through DONE -> second op accepted back-to-back, done again 128 cycles later.
- rst_n low at cycle 60 of an op -> busy, done, quotient, remainder all 0 immediately; no done pulse afterwards; a new start works normally.
- divisor=0, dividend=0x1234 -> with DIV_ZERO_CHECK_EN: done 1 cycle after start, div_by_zero=1, quotient all ones, remainder=0x1234. Without: done after 128 cycles, same quotient/remainder, div_by_zero=0.

Source files
------------

// File: rtl/div128_64_seq.sv
// rtl/div128_64_seq.sv - iterative restoring divider, 2*WIDTH / WIDTH bits, one quotient bit per clock
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   dividend     2*WIDTH-bit numerator, captured when start is accepted
//   divisor      WIDTH-bit denominator, captured when start is accepted
//   busy         operation in progress
//   done         one-cycle pulse, quotient/remainder valid
//   quotient     2*WIDTH-bit unsigned quotient, held until the next done
//   remainder    WIDTH-bit unsigned remainder, held likewise
//   div_by_zero  divisor was zero (only with DIV_ZERO_CHECK_EN, else tied 0)
//
// Optional feature macro: DIV_ZERO_CHECK_EN (zero-divisor fast path, latency 1)

module div128_64_seq #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // q_sh starts as the dividend; each iteration shifts its MSB into the
    // partial remainder and shifts the new quotient bit in at the bottom, so
    // after QW iterations it holds the full quotient.
    logic [QW-1:0]    q_sh;
    logic [WIDTH-1:0] dvs;
    // After every step the partial remainder is below the divisor, so only
    // WIDTH bits need storing; the extra bit lives in pr_shift for the compare.
    logic [WIDTH-1:0] pr;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   pr_shift;
    logic             q_bit;
    logic [WIDTH-1:0] pr_nxt;
    logic [QW-1:0]    q_nxt;

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        pr_shift = {pr, q_sh[QW-1]};
        q_bit    = (pr_shift >= {1'b0, dvs});
        // Difference is below dvs when taken, so the low WIDTH bits are exact.
        pr_nxt   = q_bit ? (pr_shift[WIDTH-1:0] - dvs) : pr_shift[WIDTH-1:0];
        q_nxt    = {q_sh[QW-2:0], q_bit};
    end

`ifdef DIV_ZERO_CHECK_EN
    logic zdet;
    logic dz_r;

    assign last_iter   = zdet || (cnt == CW'(QW - 1));
    assign div_by_zero = dz_r;
`else
    assign last_iter   = (cnt == CW'(QW - 1));
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_iter ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh      <= '0;
            dvs       <= '0;
            pr        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            zdet      <= 1'b0;
            dz_r      <= 1'b0;
`endif
        end else if (accept) begin
            q_sh <= dividend;
            dvs  <= divisor;
            pr   <= '0;
            cnt  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            zdet <= (divisor == '0);
            dz_r <= 1'b0;
`endif
        end else if (state == RUN) begin
            q_sh <= q_nxt;
            pr   <= pr_nxt;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
`ifdef DIV_ZERO_CHECK_EN
                if (zdet) begin
                    // q_sh still holds the untouched dividend on this first RUN edge.
                    quotient  <= '1;
                    remainder <= q_sh[WIDTH-1:0];
                    dz_r      <= 1'b1;
                end else begin
                    quotient  <= q_nxt;
                    remainder <= pr_nxt;
                end
`else
                quotient  <= q_nxt;
                remainder <= pr_nxt;
`endif
            end
        end
    end

endmodule
